// File: rtl/see_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | see_pkg : shared types and limits for the SEE cone checker          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package see_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRANS = 2'd1,
        PERS  = 2'd2
    } see_state_e;

    localparam int PERSIST_MIN = 2;
    localparam int PERSIST_MAX = 15;

    function automatic int run_width(input int persist);
        return $clog2(persist + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/see_cone_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | see_cone_checker_if : sample inputs and result outputs of checker   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface see_cone_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             clr;
    logic             in_valid;
    logic [WIDTH-1:0] golden;
    logic [WIDTH-1:0] faulty;
    logic [WIDTH-1:0] mask;

    logic             err_now;
    logic [WIDTH-1:0] err_bits;
    logic [1:0]       state;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] trans_cnt;
    logic [CNT_W-1:0] pers_cnt;
    logic             first_valid;
    logic [CNT_W-1:0] first_idx;
    logic [WIDTH-1:0] first_bits;

    modport master (
        output clr, in_valid, golden, faulty, mask,
        input  err_now, err_bits, state, err_cnt, trans_cnt, pers_cnt,
               first_valid, first_idx, first_bits
    );

    modport slave (
        input  clr, in_valid, golden, faulty, mask,
        output err_now, err_bits, state, err_cnt, trans_cnt, pers_cnt,
               first_valid, first_idx, first_bits
    );
endinterface
`default_nettype wire

// File: rtl/see_sat_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | see_sat_cnt : saturating up-counter with synchronous clear          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module see_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule
`default_nettype wire

// File: rtl/see_cone_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | see_cone_checker : golden vs fault-injected cone comparison with    |
// | transient/persistent burst classification and first-error capture   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module see_cone_checker
    import see_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int PERSIST = 3
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    see_cone_checker_if.slave bus
);
    localparam int             RUN_W         = run_width(PERSIST);
    localparam logic [RUN_W-1:0] c_persist_run = RUN_W'(PERSIST);
    localparam logic [RUN_W-1:0] c_run_one     = RUN_W'(1);

    if ((PERSIST < PERSIST_MIN) || (PERSIST > PERSIST_MAX)) begin : g_bad_persist
        $error("see_cone_checker: PERSIST out of range");
    end

    logic [WIDTH-1:0] w_diff;
    logic             w_mis;
    logic             w_err_inc;
    logic             w_trans_inc;
    logic             w_pers_inc;
    logic [CNT_W-1:0] w_idx;
    logic [RUN_W-1:0] w_run_next;

    see_state_e       state_q,       state_d;
    logic [RUN_W-1:0] run_q,         run_d;
    logic             err_now_q,     err_now_d;
    logic [WIDTH-1:0] err_bits_q,    err_bits_d;
    logic             first_valid_q, first_valid_d;
    logic [CNT_W-1:0] first_idx_q,   first_idx_d;
    logic [WIDTH-1:0] first_bits_q,  first_bits_d;

    assign w_diff     = (bus.golden ^ bus.faulty) & bus.mask;
    assign w_mis      = |w_diff;
    assign w_run_next = run_q + c_run_one;

    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        err_now_d     = err_now_q;
        err_bits_d    = err_bits_q;
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        first_bits_d  = first_bits_q;
        w_err_inc     = 1'b0;
        w_trans_inc   = 1'b0;
        w_pers_inc    = 1'b0;

        // clr wins over a coincident sample; that sample is dropped entirely
        if (bus.clr) begin
            state_d       = IDLE;
            run_d         = '0;
            err_now_d     = 1'b0;
            err_bits_d    = '0;
            first_valid_d = 1'b0;
            first_idx_d   = '0;
            first_bits_d  = '0;
        end else if (bus.in_valid) begin
            err_now_d  = w_mis;
            err_bits_d = w_diff;
            w_err_inc  = w_mis;

            if (w_mis && !first_valid_q) begin
                first_valid_d = 1'b1;
                first_idx_d   = w_idx;
                first_bits_d  = w_diff;
            end

            case (state_q)
                IDLE: begin
                    if (w_mis) begin
                        state_d = TRANS;
                        run_d   = c_run_one;
                    end
                end
                TRANS: begin
                    if (w_mis) begin
                        run_d = w_run_next;
                        if (w_run_next == c_persist_run) begin
                            state_d    = PERS;
                            w_pers_inc = 1'b1;
                        end
                    end else begin
                        state_d     = IDLE;
                        run_d       = '0;
                        w_trans_inc = 1'b1;
                    end
                end
                PERS: begin
                    if (w_mis) begin
                        run_d = c_persist_run;
                    end else begin
                        state_d = IDLE;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            run_q         <= '0;
            err_now_q     <= 1'b0;
            err_bits_q    <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            first_bits_q  <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            err_now_q     <= err_now_d;
            err_bits_q    <= err_bits_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            first_bits_q  <= first_bits_d;
        end
    end

    see_sat_cnt #(.CNT_W(CNT_W)) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (bus.in_valid),
        .cnt   (w_idx)
    );

    see_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (w_err_inc),
        .cnt   (bus.err_cnt)
    );

    see_sat_cnt #(.CNT_W(CNT_W)) u_trans_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (w_trans_inc),
        .cnt   (bus.trans_cnt)
    );

    see_sat_cnt #(.CNT_W(CNT_W)) u_pers_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (w_pers_inc),
        .cnt   (bus.pers_cnt)
    );

    assign bus.err_now     = err_now_q;
    assign bus.err_bits    = err_bits_q;
    assign bus.state       = state_q;
    assign bus.first_valid = first_valid_q;
    assign bus.first_idx   = first_idx_q;
    assign bus.first_bits  = first_bits_q;
endmodule
`default_nettype wire

// File: tb/tb_see_cone_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_see_cone_checker : table + scoreboard bench for see_cone_checker |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_see_cone_checker;

    typedef struct {
        logic        en;
        logic [7:0]  eb;
        logic [1:0]  st;
        logic [15:0] ec;
        logic [15:0] tc;
        logic [15:0] pc;
        logic        fv;
        logic [15:0] fi;
        logic [7:0]  fb;
    } obs_t;

    typedef struct {
        logic       v;
        logic       c;
        logic [7:0] g;
        logic [7:0] f;
        logic [7:0] m;
        obs_t       e;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    obs_t sb_q[$];
    vec_t tbl[26];

    see_cone_checker_if #(.WIDTH(8), .CNT_W(16)) bus_a ();
    see_cone_checker_if #(.WIDTH(8), .CNT_W(4))  bus_b ();

    see_cone_checker #(.WIDTH(8), .CNT_W(16), .PERSIST(3)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    see_cone_checker #(.WIDTH(8), .CNT_W(4), .PERSIST(3)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mko(input logic en, input logic [7:0] eb, input logic [1:0] st,
                                 input int ec, input int tc, input int pc,
                                 input logic fv, input int fi, input logic [7:0] fb);
        obs_t o;
        o.en = en; o.eb = eb; o.st = st;
        o.ec = 16'(ec); o.tc = 16'(tc); o.pc = 16'(pc);
        o.fv = fv; o.fi = 16'(fi); o.fb = fb;
        return o;
    endfunction

    function automatic vec_t mkv(input logic v, input logic c, input logic [7:0] g,
                                 input logic [7:0] f, input logic [7:0] m, input obs_t e);
        vec_t r;
        r.v = v; r.c = c; r.g = g; r.f = f; r.m = m; r.e = e;
        return r;
    endfunction

    function automatic obs_t get_obs(input bit sel_b);
        obs_t o;
        if (!sel_b) begin
            o = mko(bus_a.err_now, bus_a.err_bits, bus_a.state, int'(bus_a.err_cnt),
                    int'(bus_a.trans_cnt), int'(bus_a.pers_cnt), bus_a.first_valid,
                    int'(bus_a.first_idx), bus_a.first_bits);
        end else begin
            o = mko(bus_b.err_now, bus_b.err_bits, bus_b.state, int'(bus_b.err_cnt),
                    int'(bus_b.trans_cnt), int'(bus_b.pers_cnt), bus_b.first_valid,
                    int'(bus_b.first_idx), bus_b.first_bits);
        end
        return o;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s actual=%0h required=%0h", tag, fld, act, exp);
    endtask

    task automatic cmp(input string tag, input obs_t a, input obs_t e);
        chk(tag, "err_now",     16'(a.en), 16'(e.en));
        chk(tag, "err_bits",    16'(a.eb), 16'(e.eb));
        chk(tag, "state",       16'(a.st), 16'(e.st));
        chk(tag, "err_cnt",     a.ec, e.ec);
        chk(tag, "trans_cnt",   a.tc, e.tc);
        chk(tag, "pers_cnt",    a.pc, e.pc);
        chk(tag, "first_valid", 16'(a.fv), 16'(e.fv));
        chk(tag, "first_idx",   a.fi, e.fi);
        chk(tag, "first_bits",  16'(a.fb), 16'(e.fb));
    endtask

    // Drive one sample, queue its expectation, then check it one edge later.
    task automatic apply(input bit sel_b, input string tag, input vec_t v);
        obs_t e;
        @(negedge clk);
        if (!sel_b) begin
            bus_a.in_valid = v.v; bus_a.clr = v.c;
            bus_a.golden = v.g; bus_a.faulty = v.f; bus_a.mask = v.m;
        end else begin
            bus_b.in_valid = v.v; bus_b.clr = v.c;
            bus_b.golden = v.g; bus_b.faulty = v.f; bus_b.mask = v.m;
        end
        sb_q.push_back(v.e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s scoreboard empty actual=0 required=1", tag);
        end else begin
            e = sb_q.pop_front();
            cmp(tag, get_obs(sel_b), e);
        end
        if (!sel_b) bus_a.in_valid = 1'b0; else bus_b.in_valid = 1'b0;
        if (!sel_b) bus_a.clr = 1'b0;      else bus_b.clr = 1'b0;
    endtask

    initial begin
        obs_t z;
        obs_t e;
        n_pass  = 0;
        n_total = 0;
        z = mko(0, 8'h00, 2'd0, 0, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 5; i++) tbl[i] = mkv(1, 0, 8'hA5, 8'hA5, 8'hFF, z);
        tbl[5]  = mkv(1, 1, 8'hA5, 8'hA4, 8'hFF, z);
        tbl[6]  = mkv(1, 0, 8'hA5, 8'hA5, 8'hFF, z);
        tbl[7]  = mkv(1, 0, 8'hA5, 8'hA5, 8'hFF, z);
        tbl[8]  = mkv(1, 0, 8'hA5, 8'hA5, 8'hFF, z);
        tbl[9]  = mkv(1, 0, 8'hA5, 8'hA4, 8'hFF, mko(1, 8'h01, 2'd1, 1, 0, 0, 1, 3, 8'h01));
        tbl[10] = mkv(1, 0, 8'hA5, 8'hA5, 8'hFF, mko(0, 8'h00, 2'd0, 1, 1, 0, 1, 3, 8'h01));
        tbl[11] = mkv(0, 1, 8'hA5, 8'hA5, 8'hFF, z);
        tbl[12] = mkv(1, 0, 8'hA5, 8'hA1, 8'hFF, mko(1, 8'h04, 2'd1, 1, 0, 0, 1, 0, 8'h04));
        tbl[13] = mkv(0, 0, 8'hA5, 8'h00, 8'hFF, mko(1, 8'h04, 2'd1, 1, 0, 0, 1, 0, 8'h04));
        tbl[14] = mkv(1, 0, 8'hA5, 8'h25, 8'hFF, mko(1, 8'h80, 2'd1, 2, 0, 0, 1, 0, 8'h04));
        tbl[15] = mkv(0, 0, 8'h00, 8'hFF, 8'hFF, mko(1, 8'h80, 2'd1, 2, 0, 0, 1, 0, 8'h04));
        tbl[16] = mkv(1, 0, 8'hA5, 8'hA1, 8'hFF, mko(1, 8'h04, 2'd2, 3, 0, 1, 1, 0, 8'h04));
        tbl[17] = mkv(1, 0, 8'hA5, 8'hA4, 8'hFF, mko(1, 8'h01, 2'd2, 4, 0, 1, 1, 0, 8'h04));
        tbl[18] = mkv(1, 0, 8'hA5, 8'hA5, 8'hFF, mko(0, 8'h00, 2'd0, 4, 0, 1, 1, 0, 8'h04));
        tbl[19] = mkv(1, 0, 8'hA5, 8'hA4, 8'hFE, mko(0, 8'h00, 2'd0, 4, 0, 1, 1, 0, 8'h04));
        tbl[20] = mkv(1, 0, 8'hA5, 8'hA4, 8'hFF, mko(1, 8'h01, 2'd1, 5, 0, 1, 1, 0, 8'h04));
        tbl[21] = mkv(1, 1, 8'hA5, 8'hA4, 8'hFF, z);
        tbl[22] = mkv(1, 0, 8'hA5, 8'hA5, 8'hFF, z);
        tbl[23] = mkv(1, 0, 8'hA5, 8'hA4, 8'hFF, mko(1, 8'h01, 2'd1, 1, 0, 0, 1, 1, 8'h01));
        tbl[24] = mkv(1, 0, 8'hA5, 8'hA7, 8'hFF, mko(1, 8'h02, 2'd1, 2, 0, 0, 1, 1, 8'h01));
        tbl[25] = mkv(1, 0, 8'hA5, 8'hA4, 8'hFF, mko(1, 8'h01, 2'd2, 3, 0, 1, 1, 1, 8'h01));

        rst_n = 1'b0;
        bus_a.clr = 0; bus_a.in_valid = 0; bus_a.golden = 0; bus_a.faulty = 0; bus_a.mask = 0;
        bus_b.clr = 0; bus_b.in_valid = 0; bus_b.golden = 0; bus_b.faulty = 0; bus_b.mask = 0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_a", get_obs(1'b0), z);
        cmp("reset_b", get_obs(1'b1), z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) apply(1'b0, $sformatf("vec%0d", i), tbl[i]);

        // Asynchronous reset in the middle of a cycle while in PERS.
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst", get_obs(1'b0), z);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, "post_rst", mkv(1, 0, 8'hA5, 8'hA5, 8'hFF, z));

        // Narrow counters: idx saturates during the clean run, then err_cnt saturates.
        for (int i = 0; i < 20; i++)
            apply(1'b1, $sformatf("b_clean%0d", i), mkv(1, 0, 8'h3C, 8'h3C, 8'hFF, z));
        for (int k = 1; k <= 20; k++) begin
            e = mko(1, 8'h01, (k < 3) ? 2'd1 : 2'd2, (k < 15) ? k : 15, 0,
                    (k >= 3) ? 1 : 0, 1, 15, 8'h01);
            apply(1'b1, $sformatf("b_err%0d", k), mkv(1, 0, 8'h3C, 8'h3D, 8'hFF, e));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
